multicycle_cpu: RTL and testbench

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/cpu_alu.sv | 27 ++
 rtl/multicycle_cpu.sv | 137 +++++++++++++
 tb/tb_multicycle_cpu.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: FSM states,
// opcode/funct fields and ALU control encodings.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // beq compares via SUB; unknown R-type functs fall back to ADD.
    function automatic logic [3:0] alu_ctrl_for(input logic [5:0] opcode,
                                                input logic [5:0] funct);
        logic [3:0] ctrl;
        ctrl = ALU_ADD;
        if (opcode == OP_BEQ) begin
            ctrl = ALU_SUB;
        end else if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SUB:  ctrl = ALU_SUB;
                FN_AND:  ctrl = ALU_AND;
                FN_OR:   ctrl = ALU_OR;
                FN_NOR:  ctrl = ALU_NOR;
                FN_SLT:  ctrl = ALU_SLT;
                default: ctrl = ALU_ADD;
            endcase
        end
        return ctrl;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 32-bit ALU with zero flag; arithmetic wraps modulo 2^32.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_ctrl,
    output logic [31:0] y,
    output logic        zero
);

    always_comb begin
        y = '0;
        case (alu_ctrl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
            ALU_NOR: y = ~(a | b);
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset core with unified instruction/data memory that is
// preloaded while rst is held high.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                  load_data,
    output logic [31:0]                  pc,
    output logic [31:0]                  alu_out,
    output logic [31:0]                  result,
    output logic [2:0]                   state,
    output logic                         halted,
    output logic [31:0]                  instr_count
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    logic [31:0] mem  [MEM_DEPTH];
    logic [31:0] regs [32];
    logic [31:0] ir, a_reg, b_reg, simm, mdr;
    state_t      cur;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wb_dest;
    logic [31:0] alu_b, alu_y, wb_value;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign alu_ctrl = alu_ctrl_for(opcode, funct);
    assign alu_b    = (opcode == OP_RTYPE || opcode == OP_BEQ) ? b_reg : simm;
    assign wb_dest  = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_value = (opcode == OP_LW) ? mdr : alu_out;

    assign state  = cur;
    assign halted = (cur == HALT);

    cpu_alu u_alu (
        .a        (a_reg),
        .b        (alu_b),
        .alu_ctrl (alu_ctrl),
        .y        (alu_y),
        .zero     (alu_zero)
    );

    // Memory has no reset; preload only while rst is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (load_en) mem[load_addr] <= load_data;
        end else if (cur == MEMORY && opcode == OP_SW) begin
            mem[alu_out[AW+1:2]] <= b_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= FETCH;
            pc          <= RESET_PC;
            regs        <= '{default: '0};
            ir          <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            simm        <= '0;
            mdr         <= '0;
            alu_out     <= '0;
            result      <= '0;
            instr_count <= '0;
        end else begin
            case (cur)
                FETCH: begin
                    ir  <= mem[pc[AW+1:2]];
                    pc  <= pc + 32'd4;
                    cur <= DECODE;
                end
                DECODE: begin
                    a_reg <= regs[rs];
                    b_reg <= regs[rt];
                    simm  <= {{16{ir[15]}}, ir[15:0]};
                    // j redirects here but retires in EXECUTE, giving it three cycles like beq.
                    case (opcode)
                        OP_J: begin
                            pc  <= {pc[31:28], ir[25:0], 2'b00};
                            cur <= EXECUTE;
                        end
                        OP_HALT: cur <= HALT;
                        OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: cur <= EXECUTE;
                        default: begin
                            instr_count <= instr_count + 32'd1;
                            cur         <= FETCH;
                        end
                    endcase
                end
                EXECUTE: begin
                    alu_out <= alu_y;
                    if (opcode == OP_BEQ || opcode == OP_J) begin
                        if (opcode == OP_BEQ && alu_zero)
                            pc <= pc + {simm[29:0], 2'b00};
                        instr_count <= instr_count + 32'd1;
                        cur         <= FETCH;
                    end else if (opcode == OP_LW || opcode == OP_SW) begin
                        cur <= MEMORY;
                    end else begin
                        cur <= WRITEBACK;
                    end
                end
                MEMORY: begin
                    if (opcode == OP_SW) begin
                        instr_count <= instr_count + 32'd1;
                        cur         <= FETCH;
                    end else begin
                        mdr <= mem[alu_out[AW+1:2]];
                        cur <= WRITEBACK;
                    end
                end
                WRITEBACK: begin
                    if (wb_dest != 5'd0) regs[wb_dest] <= wb_value;
                    result      <= wb_value;
                    instr_count <= instr_count + 32'd1;
                    cur         <= FETCH;
                end
                HALT:    cur <= HALT;
                default: cur <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: hand-assembled programs are preloaded
// under reset and architectural state is checked at fixed cycle counts.
module tb_multicycle_cpu;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] pc, alu_out, result, instr_count;
    logic [2:0]  state;
    logic        halted;

    int unsigned total = 0;
    int unsigned bad   = 0;

    localparam logic [31:0] I_ADDI1   = 32'h2001_0005; // addi $1,$0,5
    localparam logic [31:0] I_ADDI2   = 32'h2002_0007; // addi $2,$0,7
    localparam logic [31:0] I_ADD3    = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] I_HALT    = 32'hFC00_0000;
    localparam logic [31:0] I_SW3     = 32'hAC03_0040; // sw $3,64($0)
    localparam logic [31:0] I_LW4     = 32'h8C04_0040; // lw $4,64($0)
    localparam logic [31:0] I_J8      = 32'h0800_0008; // j 0x20
    localparam logic [31:0] I_BEQ11   = 32'h1021_0002; // beq $1,$1,+2
    localparam logic [31:0] I_BEQ12   = 32'h1022_0002; // beq $1,$2,+2

    multicycle_cpu #(.MEM_DEPTH(256), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .pc          (pc),
        .alu_out     (alu_out),
        .result      (result),
        .state       (state),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poke(input int unsigned addr, input logic [31:0] data);
        rst       = 1'b1;
        load_en   = 1'b1;
        load_addr = addr[7:0];
        load_data = data;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        @(negedge clk);
        chk("rst_state",  32'(state),  32'(FETCH));
        chk("rst_pc",     pc,          32'h0);
        chk("rst_aluout", alu_out,     32'h0);
        chk("rst_result", result,      32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_count",  instr_count, 32'h0);

        // addi/addi/add/halt, with a stray preload strobe held outside reset
        poke(0, I_ADDI1); poke(1, I_ADDI2); poke(2, I_ADD3); poke(3, I_HALT);
        rst = 1'b0; load_en = 1'b1; load_addr = 8'd3; load_data = 32'h0;
        tick(3);
        chk("addi_aluout", alu_out,     32'd5);
        chk("addi_wbst",   32'(state),  32'(WRITEBACK));
        tick(1);
        chk("addi_result", result,      32'd5);
        chk("addi_count",  instr_count, 32'd1);
        chk("addi_pc",     pc,          32'h4);
        tick(8);
        chk("add_result",  result,      32'd12);
        chk("add_count",   instr_count, 32'd3);
        tick(3);
        chk("halt_flag",   32'(halted), 32'h1);
        chk("halt_state",  32'(state),  32'(HALT));
        chk("halt_count",  instr_count, 32'd3);
        chk("halt_pc",     pc,          32'h10);
        tick(5);
        chk("halt_stay",   32'(halted), 32'h1);
        chk("halt_count2", instr_count, 32'd3);
        chk("noload_mem3", dut.mem[3],  I_HALT);
        load_en = 1'b0;

        // sw/lw, with a reset pulse landing mid-EXECUTE of the sw
        poke(0, I_ADDI1); poke(1, I_ADDI2); poke(2, I_ADD3); poke(3, I_SW3);
        poke(4, I_LW4); poke(5, I_HALT); poke(16, 32'hDEAD_BEEF);
        rst = 1'b0;
        tick(14);
        chk("sw_exec_st",  32'(state),  32'(EXECUTE));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_st",  32'(state),  32'(FETCH));
        chk("mid_rst_pc",  pc,          32'h0);
        chk("mid_rst_cnt", instr_count, 32'h0);
        chk("mid_rst_res", result,      32'h0);
        chk("mid_rst_r3",  dut.regs[3], 32'h0);
        @(negedge clk);
        chk("mid_rst_mem", dut.mem[16], 32'hDEAD_BEEF);
        rst = 1'b0;
        tick(16);
        chk("sw_mem16",    dut.mem[16], 32'd12);
        chk("sw_count",    instr_count, 32'd4);
        chk("sw_pc",       pc,          32'h10);
        tick(3);
        chk("lw_aluout",   alu_out,     32'd64);
        tick(1);
        chk("lw_wbst",     32'(state),  32'(WRITEBACK));
        chk("lw_count4",   instr_count, 32'd4);
        tick(1);
        chk("lw_result",   result,      32'd12);
        chk("lw_r4",       dut.regs[4], 32'd12);
        chk("lw_count5",   instr_count, 32'd5);
        tick(3);
        chk("rerun_halt",  32'(halted), 32'h1);

        // j to 0x20 then beq taken
        poke(0, I_ADDI1); poke(1, I_ADDI2); poke(2, I_J8); poke(8, I_BEQ11);
        poke(9, I_HALT); poke(11, I_HALT);
        rst = 1'b0;
        tick(11);
        chk("j_pc",        pc,          32'h20);
        chk("j_count",     instr_count, 32'd3);
        tick(3);
        chk("beq_t_pc",    pc,          32'h2C);
        chk("beq_t_count", instr_count, 32'd4);
        chk("beq_t_st",    32'(state),  32'(FETCH));

        // beq not taken
        poke(8, I_BEQ12);
        rst = 1'b0;
        tick(14);
        chk("beq_n_pc",    pc,          32'h24);
        chk("beq_n_count", instr_count, 32'd4);

        // writes to $0 discarded; illegal opcode retires as NOP
        poke(0, 32'h2000_0009); poke(1, 32'h0000_2820); poke(2, 32'h3E00_0000);
        poke(3, I_HALT);
        rst = 1'b0;
        tick(4);
        chk("r0_result9",  result,      32'd9);
        chk("r0_reads0",   dut.regs[0], 32'h0);
        tick(4);
        chk("r0_add_res",  result,      32'h0);
        tick(2);
        chk("ill_count",   instr_count, 32'd3);
        chk("ill_pc",      pc,          32'hC);
        chk("ill_state",   32'(state),  32'(FETCH));
        tick(2);
        chk("ill_halt",    32'(halted), 32'h1);

        // signed slt and remaining ALU ops
        poke(0, 32'h2001_FFFF); poke(1, 32'h2002_0001); poke(2, 32'h0022_182A);
        poke(3, 32'h0041_182A); poke(4, 32'h0022_2022); poke(5, 32'h0022_2024);
        poke(6, 32'h0020_2025); poke(7, 32'h0040_2027); poke(8, I_HALT);
        rst = 1'b0;
        tick(4);
        chk("neg1",        result,      32'hFFFF_FFFF);
        tick(8);
        chk("slt_lt",      result,      32'd1);
        tick(4);
        chk("slt_ge",      result,      32'd0);
        tick(4);
        chk("sub",         result,      32'hFFFF_FFFE);
        tick(4);
        chk("and",         result,      32'd1);
        tick(4);
        chk("or",          result,      32'hFFFF_FFFF);
        tick(4);
        chk("nor",         result,      32'hFFFF_FFFE);
        tick(2);
        chk("alu_halt",    32'(halted), 32'h1);
        chk("alu_count",   instr_count, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
